axi_mem_slv: RTL

AXI_MEM_SLV -- requirements
Module: axi_mem_slv

---
 rtl/axi_pkg.sv | 8 +
 rtl/axi_mem_ram.sv | 21 ++
 rtl/axi_mem_slv.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst codes and FSM state encodings shared by the memory slave
package axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: simple dual-port RAM, byte-enabled write port, enabled registered read-first read port
module axi_mem_ram #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wd,
    input  logic            re,
    input  logic [AW-1:0]   ra,
    output logic [DW-1:0]   rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (re) rd <= mem[ra];
        for (int i = 0; i < DW/8; i++)
            if (we && wstrb[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
    end
endmodule

// File: rtl/axi_mem_slv.sv
// axi_mem_slv: AXI3 memory slave with independent single-outstanding read and write FSMs
module axi_mem_slv
    import axi_pkg::*;
#(
    parameter int ID_WIDTH       = 6,
    parameter int DATA_WIDTH     = 64,
    parameter int B_BURST_LENGTH = 4,
    parameter int MEM_AW         = 10
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [31:0]               s_axi_awaddr,
    input  logic [B_BURST_LENGTH-1:0] s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ID_WIDTH-1:0]       s_axi_wid,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [31:0]               s_axi_araddr,
    input  logic [B_BURST_LENGTH-1:0] s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    localparam int SB = $clog2(DATA_WIDTH/8);
    localparam logic [2:0] SIZE = 3'(SB);
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [MEM_AW-1:0] w_idx, r_idx, ram_ra;
    logic [B_BURST_LENGTH-1:0] w_len, w_cnt, r_len, r_left, r_cnt;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic aw_hs, w_hs, w_last, aw_bad, ar_bad, w_bad, w_err;
    logic ar_hs, r_hs, r_err, p_valid, out_load, issue;
    logic unused;
    assign unused = ^{s_axi_awaddr[31:MEM_AW+SB], s_axi_awaddr[SB-1:0],
                      s_axi_araddr[31:MEM_AW+SB], s_axi_araddr[SB-1:0]};
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs = s_axi_wvalid && s_axi_wready;
    assign w_last = w_cnt == w_len;
    assign aw_bad = s_axi_awburst != BURST_INCR || s_axi_awsize != SIZE;
    assign s_axi_awready = w_state == W_IDLE && !areset;
    assign s_axi_wready = w_state == W_DATA;
    assign s_axi_bvalid = w_state == W_RESP;
    assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;
    always_comb begin
        w_next = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP :
                 (s_axi_bvalid && s_axi_bready) ? W_IDLE : w_state;
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state   <= W_IDLE;
            s_axi_bid <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_bad     <= 1'b0;
            w_err     <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                w_idx     <= s_axi_awaddr[MEM_AW+SB-1:SB];
                w_len     <= s_axi_awlen;
                w_cnt     <= '0;
                w_bad     <= aw_bad;
                w_err     <= aw_bad;
            end else if (w_hs) begin
                w_idx <= w_idx + MEM_AW'(1);
                w_cnt <= w_cnt + B_BURST_LENGTH'(1);
                if (s_axi_wlast != w_last || s_axi_wid != s_axi_bid) w_err <= 1'b1;
            end
        end
    end
    // A read is issued only when the RAM output slot is empty or draining this cycle,
    // so a stalled beat simply stays parked in the RAM output register.
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs = s_axi_rvalid && s_axi_rready;
    assign ar_bad = s_axi_arburst != BURST_INCR || s_axi_arsize != SIZE;
    assign s_axi_arready = r_state == R_IDLE && !areset;
    assign s_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;
    assign out_load = p_valid && (!s_axi_rvalid || s_axi_rready);
    assign issue = ar_hs || (r_state == R_DATA && r_left != '0 && (!p_valid || out_load));
    assign ram_ra = ar_hs ? s_axi_araddr[MEM_AW+SB-1:SB] : r_idx;
    always_comb begin
        r_next = ar_hs ? R_DATA : (r_hs && s_axi_rlast) ? R_IDLE : r_state;
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= R_IDLE;
            s_axi_rid    <= '0;
            s_axi_rdata  <= '0;
            s_axi_rlast  <= 1'b0;
            s_axi_rvalid <= 1'b0;
            r_idx        <= '0;
            r_len        <= '0;
            r_left       <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            p_valid      <= 1'b0;
        end else begin
            r_state <= r_next;
            p_valid <= issue || (p_valid && !out_load);
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                r_idx     <= s_axi_araddr[MEM_AW+SB-1:SB] + MEM_AW'(1);
                r_len     <= s_axi_arlen;
                r_left    <= s_axi_arlen;
                r_cnt     <= '0;
                r_err     <= ar_bad;
            end else if (issue) begin
                r_idx  <= r_idx + MEM_AW'(1);
                r_left <= r_left - B_BURST_LENGTH'(1);
            end
            if (out_load) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= r_err ? '0 : ram_rd;
                s_axi_rlast  <= r_cnt == r_len;
                r_cnt        <= r_cnt + B_BURST_LENGTH'(1);
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end
    axi_mem_ram #(.AW(MEM_AW), .DW(DATA_WIDTH)) u_ram (
        .clk   (aclk),
        .we    (w_hs && !w_bad),
        .wa    (w_idx),
        .wstrb (s_axi_wstrb),
        .wd    (s_axi_wdata),
        .re    (issue),
        .ra    (ram_ra),
        .rd    (ram_rd)
    );
endmodule
